// File: rtl/cpu_pkg.sv
// Shared encodings for the interrupt/reset sequencer:
// FSM states, bus/push selects and vector addresses.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_RST_S1   = 4'd0,
    ST_RST_S2   = 4'd1,
    ST_RST_S3   = 4'd2,
    ST_IDLE     = 4'd3,
    ST_PUSH_PCH = 4'd4,
    ST_PUSH_PCL = 4'd5,
    ST_PUSH_P   = 4'd6,
    ST_VEC_LO   = 4'd7,
    ST_VEC_HI   = 4'd8
  } seq_state_t;

  localparam logic [1:0] BUS_NONE     = 2'b00;
  localparam logic [1:0] BUS_STACK_WR = 2'b01;
  localparam logic [1:0] BUS_VEC_RD   = 2'b10;

  localparam logic [1:0] SEL_PCH = 2'b00;
  localparam logic [1:0] SEL_PCL = 2'b01;
  localparam logic [1:0] SEL_P   = 2'b10;

  localparam logic [1:0] VSEL_NMI = 2'd0;
  localparam logic [1:0] VSEL_RST = 2'd1;
  localparam logic [1:0] VSEL_IRQ = 2'd2;

  localparam logic [15:0] NMI_VEC_LO = 16'hFFFA;
  localparam logic [15:0] NMI_VEC_HI = 16'hFFFB;
  localparam logic [15:0] RST_VEC_LO = 16'hFFFC;
  localparam logic [15:0] RST_VEC_HI = 16'hFFFD;
  localparam logic [15:0] IRQ_VEC_LO = 16'hFFFE;
  localparam logic [15:0] IRQ_VEC_HI = 16'hFFFF;

  function automatic logic [15:0] vec_addr(
    input logic [1:0] sel,
    input logic       hi
  );
    logic [15:0] a;
    case (sel)
      VSEL_NMI: a = hi ? NMI_VEC_HI : NMI_VEC_LO;
      VSEL_IRQ: a = hi ? IRQ_VEC_HI : IRQ_VEC_LO;
      default:  a = hi ? RST_VEC_HI : RST_VEC_LO;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Bus-side bundle between the sequencer and the
// core's address/stack/PSR datapath.
interface interrupt_sequencer_if;
  logic        ready;
  logic        seq_active;
  logic [1:0]  bus_op;
  logic [1:0]  push_sel;
  logic [7:0]  psr_push;
  logic        sp_dec;
  logic [15:0] vector_addr;
  logic        set_I;
  logic        seq_done;

  modport master (
    input  ready,
    output seq_active,
    output bus_op,
    output push_sel,
    output psr_push,
    output sp_dec,
    output vector_addr,
    output set_I,
    output seq_done
  );

  modport slave (
    output ready,
    input  seq_active,
    input  bus_op,
    input  push_sel,
    input  psr_push,
    input  sp_dec,
    input  vector_addr,
    input  set_I,
    input  seq_done
  );
endinterface

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for nmi_n with a sticky
// pending flag; a fresh edge beats a same-cycle clear.
module nmi_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic nmi_n,
  input  logic clr,
  output logic pend
);

  logic nmi_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmi_q <= 1'b1;
      pend  <= 1'b0;
    end else begin
      nmi_q <= nmi_n;
      if (nmi_q && !nmi_n)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset / NMI / BRK / IRQ entry sequencer: stacks
// PC and P, then fetches the selected vector.
module interrupt_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic [7:0] psr_in,
  input  logic       fetch_boundary,
  input  logic       brk_op,
  interrupt_sequencer_if.master bus
);

  localparam logic [3:0] RST_S1   = ST_RST_S1;
  localparam logic [3:0] RST_S2   = ST_RST_S2;
  localparam logic [3:0] RST_S3   = ST_RST_S3;
  localparam logic [3:0] IDLE     = ST_IDLE;
  localparam logic [3:0] PUSH_PCH = ST_PUSH_PCH;
  localparam logic [3:0] PUSH_PCL = ST_PUSH_PCL;
  localparam logic [3:0] PUSH_P   = ST_PUSH_P;
  localparam logic [3:0] VEC_LO   = ST_VEC_LO;
  localparam logic [3:0] VEC_HI   = ST_VEC_HI;

  logic [3:0] state;
  logic [3:0] nxt;
  logic [1:0] vec_sel;
  logic       b_flag;
  logic       nmi_pend;
  logic       irq_pend;
  logic       take;
  logic       commit_nmi;
  logic       hijack;

  assign irq_pend   = !irq_n && !psr_in[2];
  assign take       = (state == IDLE) && fetch_boundary &&
                      (nmi_pend || brk_op || irq_pend);
  assign commit_nmi = take && nmi_pend;
  // A late NMI steals a BRK/IRQ sequence at its last push.
  assign hijack     = (state == PUSH_P) && bus.ready &&
                      nmi_pend && (vec_sel != VSEL_NMI);

  nmi_edge_detect u_nmi (
    .clk   (clk),
    .nrst  (nrst),
    .nmi_n (nmi_n),
    .clr   (commit_nmi || hijack),
    .pend  (nmi_pend)
  );

  always_comb begin
    nxt = state;
    case (state)
      RST_S1:   nxt = RST_S2;
      RST_S2:   nxt = RST_S3;
      RST_S3:   nxt = VEC_LO;
      IDLE:     nxt = take ? PUSH_PCH : IDLE;
      PUSH_PCH: nxt = PUSH_PCL;
      PUSH_PCL: nxt = PUSH_P;
      PUSH_P:   nxt = VEC_LO;
      VEC_LO:   nxt = VEC_HI;
      VEC_HI:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= RST_S1;
      vec_sel <= VSEL_RST;
      b_flag  <= 1'b0;
    end else begin
      if (state == IDLE || bus.ready)
        state <= nxt;
      if (take) begin
        vec_sel <= nmi_pend ? VSEL_NMI : VSEL_IRQ;
        b_flag  <= !nmi_pend && brk_op;
      end else if (hijack) begin
        vec_sel <= VSEL_NMI;
      end
    end
  end

  always_comb begin
    bus.seq_active  = (state != IDLE);
    bus.bus_op      = BUS_NONE;
    bus.push_sel    = SEL_PCH;
    bus.sp_dec      = 1'b0;
    bus.vector_addr = 16'h0000;
    bus.set_I       = 1'b0;
    bus.seq_done    = 1'b0;
    bus.psr_push    = (psr_in & 8'hCF) |
                      {2'b00, 1'b1, b_flag, 4'b0000};
    unique case (1'b1)
      (state == RST_S1),
      (state == RST_S2),
      (state == RST_S3): bus.sp_dec = 1'b1;
      (state == PUSH_PCH): begin
        bus.bus_op = BUS_STACK_WR;
        bus.sp_dec = 1'b1;
      end
      (state == PUSH_PCL): begin
        bus.bus_op   = BUS_STACK_WR;
        bus.push_sel = SEL_PCL;
        bus.sp_dec   = 1'b1;
      end
      (state == PUSH_P): begin
        bus.bus_op   = BUS_STACK_WR;
        bus.push_sel = SEL_P;
        bus.sp_dec   = 1'b1;
      end
      (state == VEC_LO): begin
        bus.bus_op      = BUS_VEC_RD;
        bus.vector_addr = vec_addr(vec_sel, 1'b0);
        bus.set_I       = bus.ready;
      end
      (state == VEC_HI): begin
        bus.bus_op      = BUS_VEC_RD;
        bus.vector_addr = vec_addr(vec_sel, 1'b1);
        bus.seq_done    = bus.ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for the
// interrupt/reset sequencer.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       nmi_n;
  logic       irq_n;
  logic [7:0] psr_in;
  logic       fetch_boundary;
  logic       brk_op;

  int errors = 0;
  int checks = 0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk            (clk),
    .nrst           (nrst),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .psr_in         (psr_in),
    .fetch_boundary (fetch_boundary),
    .brk_op         (brk_op),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ck(input string tag,
                    input logic [15:0] got,
                    input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic exp_o(input string t,
                       input logic a,
                       input logic [1:0] bop,
                       input logic [1:0] ps,
                       input logic sd,
                       input logic [15:0] va,
                       input logic si,
                       input logic dn);
    ck({t, ".seq_active"}, 16'(bus.seq_active), 16'(a));
    ck({t, ".bus_op"}, 16'(bus.bus_op), 16'(bop));
    ck({t, ".push_sel"}, 16'(bus.push_sel), 16'(ps));
    ck({t, ".sp_dec"}, 16'(bus.sp_dec), 16'(sd));
    ck({t, ".vector_addr"}, bus.vector_addr, va);
    ck({t, ".set_I"}, 16'(bus.set_I), 16'(si));
    ck({t, ".seq_done"}, 16'(bus.seq_done), 16'(dn));
  endtask

  task automatic reset_seq(input string t);
    exp_o({t, ".s1"}, 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    step();
    exp_o({t, ".s2"}, 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    step();
    exp_o({t, ".s3"}, 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    step();
    exp_o({t, ".vlo"}, 1, 2'b10, 2'b00, 0, 16'hFFFC, 1, 0);
    step();
    exp_o({t, ".vhi"}, 1, 2'b10, 2'b00, 0, 16'hFFFD, 0, 1);
    step();
    exp_o({t, ".idle"}, 0, 2'b00, 2'b00, 0, 16'h0000, 0, 0);
  endtask

  task automatic pushes(input string t, input logic [7:0] p);
    exp_o({t, ".pch"}, 1, 2'b01, 2'b00, 1, 16'h0000, 0, 0);
    step();
    exp_o({t, ".pcl"}, 1, 2'b01, 2'b01, 1, 16'h0000, 0, 0);
    step();
    exp_o({t, ".pp"}, 1, 2'b01, 2'b10, 1, 16'h0000, 0, 0);
    ck({t, ".psr_push"}, 16'(bus.psr_push), 16'(p));
  endtask

  task automatic vectors(input string t, input logic [15:0] lo);
    exp_o({t, ".vlo"}, 1, 2'b10, 2'b00, 0, lo, 1, 0);
    step();
    exp_o({t, ".vhi"}, 1, 2'b10, 2'b00, 0, lo | 16'h1, 0, 1);
    step();
    exp_o({t, ".idle"}, 0, 2'b00, 2'b00, 0, 16'h0000, 0, 0);
  endtask

  initial begin
    nrst = 1'b0;
    bus.ready = 1'b1;
    nmi_n = 1'b1;
    irq_n = 1'b1;
    psr_in = 8'h00;
    fetch_boundary = 1'b0;
    brk_op = 1'b0;

    #3;
    exp_o("rst_hold0", 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    step();
    step();
    exp_o("rst_hold1", 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    nrst = 1'b1;
    reset_seq("por");

    // IRQ unmasked
    irq_n = 1'b0;
    fetch_boundary = 1'b1;
    step();
    irq_n = 1'b1;
    fetch_boundary = 1'b0;
    pushes("irq", 8'h20);
    step();
    vectors("irq", 16'hFFFE);

    // IRQ masked by I
    irq_n = 1'b0;
    psr_in = 8'h04;
    fetch_boundary = 1'b1;
    step();
    exp_o("irq_mask0", 0, 2'b00, 2'b00, 0, 16'h0000, 0, 0);
    step();
    exp_o("irq_mask1", 0, 2'b00, 2'b00, 0, 16'h0000, 0, 0);
    irq_n = 1'b1;
    fetch_boundary = 1'b0;

    // BRK
    psr_in = 8'hC3;
    brk_op = 1'b1;
    fetch_boundary = 1'b1;
    step();
    brk_op = 1'b0;
    fetch_boundary = 1'b0;
    pushes("brk", 8'hF3);
    step();
    vectors("brk", 16'hFFFE);

    // BRK hijacked by NMI edge in PUSH_PCL
    psr_in = 8'h00;
    brk_op = 1'b1;
    fetch_boundary = 1'b1;
    step();
    brk_op = 1'b0;
    fetch_boundary = 1'b0;
    exp_o("hij.pch", 1, 2'b01, 2'b00, 1, 16'h0000, 0, 0);
    step();
    exp_o("hij.pcl", 1, 2'b01, 2'b01, 1, 16'h0000, 0, 0);
    nmi_n = 1'b0;
    step();
    exp_o("hij.pp", 1, 2'b01, 2'b10, 1, 16'h0000, 0, 0);
    ck("hij.psr_push", 16'(bus.psr_push), 16'h0030);
    step();
    vectors("hij", 16'hFFFA);
    nmi_n = 1'b1;
    fetch_boundary = 1'b1;
    step();
    exp_o("hij.cleared", 0, 2'b00, 2'b00, 0, 16'h0000, 0, 0);
    fetch_boundary = 1'b0;
    step();

    // NMI beats BRK at the boundary, B stays 0
    nmi_n = 1'b0;
    step();
    brk_op = 1'b1;
    fetch_boundary = 1'b1;
    step();
    brk_op = 1'b0;
    fetch_boundary = 1'b0;
    nmi_n = 1'b1;
    pushes("nmi", 8'h20);
    step();
    vectors("nmi", 16'hFFFA);

    // ready stall in PUSH_PCL: VEC_HI at N+8
    irq_n = 1'b0;
    fetch_boundary = 1'b1;
    step();
    irq_n = 1'b1;
    fetch_boundary = 1'b0;
    exp_o("stl.pch", 1, 2'b01, 2'b00, 1, 16'h0000, 0, 0);
    step();
    bus.ready = 1'b0;
    exp_o("stl.pcl0", 1, 2'b01, 2'b01, 1, 16'h0000, 0, 0);
    step();
    exp_o("stl.pcl1", 1, 2'b01, 2'b01, 1, 16'h0000, 0, 0);
    step();
    exp_o("stl.pcl2", 1, 2'b01, 2'b01, 1, 16'h0000, 0, 0);
    step();
    exp_o("stl.pcl3", 1, 2'b01, 2'b01, 1, 16'h0000, 0, 0);
    bus.ready = 1'b1;
    step();
    exp_o("stl.pp", 1, 2'b01, 2'b10, 1, 16'h0000, 0, 0);
    step();
    vectors("stl", 16'hFFFE);

    // reset pulse during VEC_LO
    irq_n = 1'b0;
    fetch_boundary = 1'b1;
    step();
    irq_n = 1'b1;
    fetch_boundary = 1'b0;
    step();
    step();
    step();
    exp_o("abort.vlo", 1, 2'b10, 2'b00, 0, 16'hFFFE, 1, 0);
    nrst = 1'b0;
    #1;
    exp_o("abort.rst", 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    step();
    exp_o("abort.hold", 1, 2'b00, 2'b00, 1, 16'h0000, 0, 0);
    nrst = 1'b1;
    reset_seq("rerst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 nrst  in  1  reset, asynchronous, active-low.
REQ-003 nmi_n  in  1  non-maskable interrupt request, active-low, falling-edge sensitive, synchronous to clk.
REQ-004 irq_n  in  1  maskable interrupt request, active-low, level sensitive.
REQ-005 psr_in  in  8  current status register value from the RCL-side PSR output; bit 2 = I mask.
REQ-006 fetch_boundary  in  1  high in the cycle the core would start an opcode fetch.
REQ-007 brk_op  in  1  BRK decoded; valid only with fetch_boundary.
REQ-008 ready  in  1  bus ready; low stalls the sequencer in its current state.
REQ-009 seq_active  out  1  sequencer owns the bus (any non-IDLE state).
REQ-010 bus_op  out  2  00 none, 01 stack write, 10 vector read.
REQ-011 push_sel  out  2  stack write source: 00 PCH, 01 PCL, 10 P.
REQ-012 psr_push  out  8  P value for stack: psr_in with bit 5 = 1, bit 4 = B.
REQ-013 sp_dec  out  1  decrement stack pointer this cycle.
REQ-014 vector_addr  out  16  vector address for bus_op = 10, else 16'h0000.
REQ-015 set_I  out  1  one-cycle pulse driving the PSR manual I-set path.
REQ-016 seq_done  out  1  one-cycle pulse on completion of the final vector read.

Function
REQ-017 States: RST_S1, RST_S2, RST_S3, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
REQ-018 Non-IDLE states advance only on ready = 1; with ready = 0 state and all outputs hold.
REQ-019 RST_S1 -> RST_S2 -> RST_S3 -> VEC_LO -> VEC_HI -> IDLE; RST_Sx: sp_dec = 1, bus_op = 00.
REQ-020 NMI edge: latch nmi_pend when previous sampled nmi_n = 1 and current = 0; held until consumed.
REQ-021 IRQ pending: irq_n = 0 and psr_in[2] = 0, evaluated at fetch_boundary only; not latched.
REQ-022 From IDLE at fetch_boundary, priority NMI > BRK > IRQ; winner starts PUSH_PCH next cycle.
REQ-023 PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> IDLE; push states: bus_op = 01, sp_dec = 1.
REQ-024 Latency: trigger cycle N, PUSH_PCH at N+1, VEC_HI at N+5 (ready held high).
REQ-025 B bit (psr_push[4]) = 1 for BRK, 0 for NMI/IRQ; psr_push sampled from psr_in in PUSH_P.
REQ-026 Vectors: NMI FFFA/FFFB, RESET FFFC/FFFD, IRQ/BRK FFFE/FFFF (VEC_LO/VEC_HI).
REQ-027 set_I asserted for exactly one cycle on entry to VEC_LO, all sequence types.
REQ-028 NMI hijack: nmi_pend set before leaving PUSH_P during BRK/IRQ switches vector to FFFA and clears nmi_pend; B unchanged.
REQ-029 nmi_pend clears on the cycle a NMI sequence (or hijack) is committed; a new edge during the sequence is retained.
REQ-030 seq_done pulses in VEC_HI when ready = 1.
REQ-031 IRQ deasserted after commit does not abort the sequence.

Reset
REQ-032 nrst low: state = RST_S1, nmi_pend = 0, nmi_n history = 1, B = 0, vector select = RESET.
REQ-033 Outputs during reset follow RST_S1: seq_active 1, sp_dec 1, bus_op 00, set_I 0, seq_done 0, vector_addr 0000.
REQ-034 Reset asserted mid-sequence aborts immediately; reset sequence restarts after release.

Structure
REQ-035 cpu_pkg holds seq_state_t enum, bus_op and push_sel encodings, and the six vector address constants.
REQ-036 One sub-module nmi_edge_detect (history flop, pending latch, clear input).

Verification
REQ-037 Release nrst, ready = 1 -> 3 sp_dec cycles, then FFFC, FFFD reads, set_I once, seq_done, IDLE.
REQ-038 irq_n = 0, psr_in = 8'h00 at boundary -> pushes PCH, PCL, P = 8'h20, vector FFFE/FFFF; with psr_in = 8'h04 -> stays IDLE.
REQ-039 brk_op with psr_in = 8'hC3 -> psr_push = 8'hF3, vector FFFE.
REQ-040 nmi_n falling during BRK PUSH_PCL -> psr_push 8'h30-based B = 1, vector FFFA/FFFB, nmi_pend cleared.
REQ-041 ready = 0 for 3 cycles in PUSH_PCL -> outputs frozen, VEC_HI reached at N+8.
REQ-042 nrst pulsed during VEC_LO -> immediate RST_S1, full reset sequence follows.
